// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Expected parity bit for a byte under the given mode (0 when no parity).
    function automatic logic calc_parity(input logic [7:0] data, input int mode);
        logic p;
        p = 1'b0;
        if (mode == PARITY_EVEN) begin
            p = ^data;
        end else if (mode == PARITY_ODD) begin
            p = ~(^data);
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1,
    parameter int   STAGES    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= {STAGES{RESET_VAL}};
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/uart_rx_framer.sv
// UART receiver: start/8 data/optional parity/stop framing with 3-sample
// majority voting and a one-entry valid/ready holding register.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BIT_RATE     = 115200,
    parameter int PARITY       = 1,
    parameter int CLKS_PER_BIT = CLK_FREQ / BIT_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int MID   = CLKS_PER_BIT / 2;

    // cnt_reg trails the rx_s bit offset by one (edge-detect register), so the
    // samples at offsets MID-1, MID, MID+1 are taken at cnt MID-2, MID-1, MID.
    localparam logic [CNT_W-1:0] SMP_A_C = CNT_W'(MID - 2);
    localparam logic [CNT_W-1:0] SMP_B_C = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] MID_C   = CNT_W'(MID);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_rate
            $error("uart_rx_framer: CLKS_PER_BIT must be at least 4");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_rx_framer: PARITY must be 0, 1 or 2");
        end
    endgenerate

    logic             rx_s;
    logic             prev_reg;
    logic [1:0]       settle_reg;
    rx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_cnt_reg, bit_cnt_next;
    logic [7:0]       shift_reg, shift_next;
    logic             par_err_reg, par_err_next;
    logic             samp_a_reg, samp_b_reg;
    logic             maj, at_mid, bit_end, armed, commit;

    logic [7:0]       data_reg;
    logic             valid_reg, perr_out_reg, ferr_out_reg, ovr_reg;

    uart_sync #(.RESET_VAL(1'b1), .STAGES(2)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign maj     = (samp_a_reg & samp_b_reg) | (samp_a_reg & rx_s) | (samp_b_reg & rx_s);
    assign at_mid  = (cnt_reg == MID_C);
    assign bit_end = (cnt_reg == LAST_C);
    // The edge detector only trusts prev_reg once the synchronizer has flushed
    // its reset value, so a line held low through reset is not seen as a start.
    assign armed   = (settle_reg == 2'd3);
    assign commit  = (state_reg == RX_STOP) && at_mid;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_reg    <= 1'b1;
            settle_reg  <= 2'd0;
            state_reg   <= RX_IDLE;
            cnt_reg     <= '0;
            bit_cnt_reg <= 3'd0;
            shift_reg   <= 8'd0;
            par_err_reg <= 1'b0;
            samp_a_reg  <= 1'b1;
            samp_b_reg  <= 1'b1;
        end else begin
            prev_reg    <= rx_s;
            if (settle_reg != 2'd3) begin
                settle_reg <= settle_reg + 2'd1;
            end
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            par_err_reg <= par_err_next;
            if (cnt_reg == SMP_A_C) begin
                samp_a_reg <= rx_s;
            end
            if (cnt_reg == SMP_B_C) begin
                samp_b_reg <= rx_s;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = bit_end ? '0 : cnt_reg + CNT_W'(1);
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        par_err_next = par_err_reg;
        case (state_reg)
            RX_IDLE: begin
                cnt_next     = '0;
                bit_cnt_next = 3'd0;
                if (armed && prev_reg && !rx_s) begin
                    state_next   = RX_START;
                    par_err_next = 1'b0;
                end
            end
            RX_START: begin
                if (at_mid && maj) begin
                    state_next = RX_IDLE;
                    cnt_next   = '0;
                end else if (bit_end) begin
                    state_next = RX_DATA;
                end
            end
            RX_DATA: begin
                if (at_mid) begin
                    shift_next = {maj, shift_reg[7:1]};
                end
                if (bit_end) begin
                    if (bit_cnt_reg == 3'd7) begin
                        bit_cnt_next = 3'd0;
                        state_next   = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (at_mid) begin
                    par_err_next = (maj != calc_parity(shift_reg, PARITY));
                end
                if (bit_end) begin
                    state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                // Leave at mid-stop so a following start bit is caught on time.
                if (at_mid) begin
                    state_next = RX_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = RX_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg     <= 8'd0;
            valid_reg    <= 1'b0;
            perr_out_reg <= 1'b0;
            ferr_out_reg <= 1'b0;
            ovr_reg      <= 1'b0;
        end else begin
            ovr_reg <= 1'b0;
            if (commit) begin
                if (!valid_reg || rx_ready) begin
                    data_reg     <= shift_reg;
                    perr_out_reg <= par_err_reg;
                    ferr_out_reg <= ~maj;
                    valid_reg    <= 1'b1;
                end else begin
                    ovr_reg <= 1'b1;
                end
            end else if (valid_reg && rx_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign rx_data       = data_reg;
    assign rx_valid      = valid_reg;
    assign rx_parity_err = perr_out_reg;
    assign rx_frame_err  = ferr_out_reg;
    assign rx_overrun    = ovr_reg;
    assign rx_busy       = (state_reg != RX_IDLE);

endmodule
